// File: rtl/fp_to_dec_if.sv
// -----------------------------------------------------------------------------
// fp_to_dec_if
// Handshake bundle for the float-code to integer converter.
//   in_valid / in_ready   : input code handshake (producer -> converter)
//   sign, exp, mant       : compact float code (S, E[2:0], M[3:0])
//   out_valid / out_ready : result handshake (converter -> consumer)
//   dec                   : 12-bit two's-complement result
// Modports:
//   master : the side that supplies codes and consumes results
//   slave  : the converter itself
// -----------------------------------------------------------------------------
interface fp_to_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [2:0]  exp;
  logic [3:0]  mant;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] dec;

  modport master (
    output in_valid,
    input  in_ready,
    output sign,
    output exp,
    output mant,
    input  out_valid,
    output out_ready,
    input  dec
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  sign,
    input  exp,
    input  mant,
    output out_valid,
    input  out_ready,
    output dec
  );
endinterface

// File: rtl/fp_to_dec.sv
// -----------------------------------------------------------------------------
// fp_to_dec
// Converts a compact float code value = (-1)^S * M * 2^E into a 12-bit
// two's-complement integer using a one-bit-per-cycle left shifter.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : fp_to_dec_if.slave (input code handshake, result handshake)
// Flow: IDLE -(accept)-> SHIFT (E shifts, then one edge to leave) -> SIGN
//       (apply sign into dec) -> DONE (hold until out_ready) -> IDLE.
// -----------------------------------------------------------------------------
module fp_to_dec (
  input  logic         clk,
  input  logic         rst,
  fp_to_dec_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        s_q, s_d;
  logic [11:0] dec_q, dec_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  // 12-bit negate of the zero-extended magnitude; negative zero folds to 0.
  function automatic logic [11:0] apply_sign(input logic neg, input logic [10:0] mag);
    logic [11:0] ext;
    ext = {1'b0, mag};
    if (neg) begin
      return ~ext + 12'd1;
    end else begin
      return ext;
    end
  endfunction

  // Next-state, datapath and handshake-flag computation.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        // in_ready_q is high exactly in IDLE, so it doubles as the accept gate
        if (bus.in_valid && in_ready_q) begin
          mag_d   = {7'd0, bus.mant};
          cnt_d   = bus.exp;
          s_d     = bus.sign;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // max magnitude 15 << 7 = 1920 fits in 11 bits, so no overflow check
        if (cnt_q != 3'd0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        dec_d   = apply_sign(s_q, mag_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Flags are registered from the next state so they depend on state only.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= 11'd0;
      cnt_q       <= 3'd0;
      s_q         <= 1'b0;
      dec_q       <= 12'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      dec_q       <= dec_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dec       = dec_q;

endmodule

// File: tb/tb_fp_to_dec.sv
// -----------------------------------------------------------------------------
// tb_fp_to_dec
// Self-checking bench for fp_to_dec. Expected results come from plain
// arithmetic (M * 2^E with sign) and an FPCVT-style encoder model.
// -----------------------------------------------------------------------------
module tb_fp_to_dec;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fp_to_dec_if bus ();

  fp_to_dec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait was somehow missed.
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: signed value of M << E, wrapped to 12 bits.
  function automatic logic [11:0] ref_dec(input logic s, input logic [2:0] e, input logic [3:0] m);
    int v;
    v = int'(m) * (1 << int'(e));
    if (s) v = -v;
    return v[11:0];
  endfunction

  // Reference FPCVT: 12-bit two's complement -> {S, E, M} by normalising
  // the magnitude down into 0..15 and counting the shifts.
  function automatic logic [7:0] fpcvt(input logic [11:0] d);
    int   mag;
    int   e;
    logic s;
    s = d[11];
    if (s) mag = 4096 - int'(d);
    else   mag = int'(d);
    e = 0;
    while (mag >= 16 && e < 7) begin
      mag = mag / 2;
      e++;
    end
    return {s, e[2:0], mag[3:0]};
  endfunction

  // Drives one code and returns latency (edges after accept until out_valid)
  // and the result; lat = -1 when out_valid never shows up.
  task automatic run_code(input logic s, input logic [2:0] e, input logic [3:0] m,
                          input int stall, output int lat, output logic [11:0] d);
    int          guard;
    logic [31:0] r;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.sign      = s;
    bus.exp       = e;
    bus.mant      = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    r = $urandom;
    bus.sign = r[0];
    bus.exp  = r[3:1];
    bus.mant = r[7:4];
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = bus.dec;
    if (!bus.out_valid) begin
      lat = -1;
      return;
    end
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.dec !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_dec: got %h want 000", bus.dec);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0]  code_t [4] = '{8'h3C, 8'hFF, 8'h80, 8'h50};
    logic [11:0] dec_t  [4] = '{12'h060, 12'h880, 12'h000, 12'h000};
    int          lat_t  [4] = '{5, 9, 2, 7};
    int          lat;
    logic [11:0] d;
    logic [7:0]  c;
    for (int i = 0; i < 4; i++) begin
      c = code_t[i];
      run_code(c[7], c[6:4], c[3:0], 0, lat, d);
      n_checks++;
      if (d !== dec_t[i]) begin
        n_fail++;
        $display("FAIL directed_dec[%0d]: got %h want %h", i, d, dec_t[i]);
      end
      n_checks++;
      if (lat !== lat_t[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, lat_t[i]);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b want 1/0",
                 i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.sign      = 1'b0;
    bus.exp       = 3'd1;
    bus.mant      = 4'd9;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    for (int k = 0; k < 5; k++) begin
      // Second code offered while busy must be ignored.
      bus.in_valid = (k == 2);
      bus.sign     = 1'b1;
      bus.exp      = 3'd7;
      bus.mant     = 4'd15;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.dec !== 12'h012 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b dec=%h in_ready=%b want 1/012/0",
                 k, bus.out_valid, bus.dec, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.dec !== 12'h012) begin
      n_fail++;
      $display("FAIL bp_before_ready: out_valid=%b dec=%h want 1/012", bus.out_valid, bus.dec);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dec !== 12'h012) begin
      n_fail++;
      $display("FAIL bp_consume: out_valid=%b in_ready=%b dec=%h want 0/1/012",
               bus.out_valid, bus.in_ready, bus.dec);
    end
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_no_second[%0d]: out_valid=%b want 0", k, bus.out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_shift();
    bus.sign      = 1'b0;
    bus.exp       = 3'd6;
    bus.mant      = 4'd11;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;  // accept edge 0
    bus.in_valid = 1'b0;
    @(posedge clk); #1;  // edge 1
    @(posedge clk); #1;  // edge 2
    rst = 1'b1;
    @(posedge clk); #1;  // edge 3 samples reset
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dec !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_shift: in_ready=%b out_valid=%b dec=%h want 1/0/000",
               bus.in_ready, bus.out_valid, bus.dec);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_pulse[%0d]: out_valid=%b want 0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    int          lat;
    logic [11:0] d;
    logic [11:0] exp_d;
    logic [7:0]  c;
    logic [7:0]  rt;
    for (int i = 0; i < 256; i++) begin
      c = i[7:0];
      run_code(c[7], c[6:4], c[3:0], 0, lat, d);
      exp_d = ref_dec(c[7], c[6:4], c[3:0]);
      n_checks++;
      if (d !== exp_d) begin
        n_fail++;
        $display("FAIL sweep_dec code=%h: got %h want %h", c, d, exp_d);
      end
      n_checks++;
      if (lat !== int'(c[6:4]) + 2) begin
        n_fail++;
        $display("FAIL sweep_latency code=%h: got %0d want %0d", c, lat, int'(c[6:4]) + 2);
      end
      if ((c[3] || c[6:4] == 3'd0) && !(c[7] && c[3:0] == 4'd0)) begin
        rt = fpcvt(d);
        n_checks++;
        if (rt !== c) begin
          n_fail++;
          $display("FAIL sweep_roundtrip code=%h: got %h want %h", c, rt, c);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    int          stall;
    logic [11:0] d;
    logic [11:0] exp_d;
    logic [31:0] r;
    for (int i = 0; i < 40; i++) begin
      r     = $urandom;
      stall = $urandom_range(0, 3);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, bus.in_ready);
      end
      run_code(r[0], r[3:1], r[7:4], stall, lat, d);
      exp_d = ref_dec(r[0], r[3:1], r[7:4]);
      n_checks++;
      if (d !== exp_d || lat !== int'(r[3:1]) + 2) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got dec=%h lat=%0d want dec=%h lat=%0d",
                 i, d, lat, exp_d, int'(r[3:1]) + 2);
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sign      = 1'b0;
    bus.exp       = 3'd0;
    bus.mant      = 4'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_to_dec.md
# fp_to_dec

Sequential inverse of the 12-bit-to-float converter `FPCVT`. It takes a compact floating-point code (1-bit sign, 3-bit exponent, 4-bit mantissa) and produces the equivalent 12-bit two's-complement integer, value = (−1)^S · M · 2^E. The block sits on the lab datapath behind a valid/ready pair on each side. It uses an iterative one-bit-per-cycle shifter so the bench can round-trip codes through `FPCVT` and back.

## Interface
- Parameters: none; widths are fixed by the format (S=1, E=3, M=4, result=12).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  input code is presented.
- `in_ready`  output  1  block can accept a code; high only in IDLE.
- `sign`  input  1  S bit; sampled only on accept.
- `exp`  input  3  E field, 0–7; sampled only on accept.
- `mant`  input  4  M field, unsigned 0–15; sampled only on accept.
- `out_valid`  output  1  `dec` holds a completed result; high only in DONE.
- `out_ready`  input  1  consumer takes the result.
- `dec`  output  12  two's-complement result, registered.

## Operation
- Internal registers: state, 11-bit magnitude `mag`, 3-bit counter `cnt`, latched sign `s_q`, 12-bit `dec`.
- Accept: `in_valid && in_ready` at a rising edge.
  - Loads `mag = {7'b0, mant}`, `cnt = exp`, `s_q = sign`.
  - Moves to SHIFT.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - Stays in IDLE until accept.
- SHIFT:
  - If `cnt != 0`: `mag <= mag << 1` and `cnt <= cnt − 1`.
  - If `cnt == 0`: go to SIGN.
  - Maximum magnitude is 15·2^7 = 1920, so `mag` never overflows 11 bits.
- SIGN:
  - `dec <= s_q ? (~{1'b0,mag} + 1) : {1'b0,mag}`, a 12-bit negate.
  - Then go to DONE.
  - Negative zero (S=1, M=0) yields 12'h000.
  - The range is −1920..+1920, so there is no saturation case.
- DONE:
  - `out_valid` = 1.
  - On `out_ready` = 1 at an edge, go to IDLE.
  - Otherwise hold, with `dec` stable.
- `dec` keeps its last value after the handshake, until the next SIGN state overwrites it.
- Input changes after accept are ignored.
- `in_valid` outside IDLE is ignored; no queuing.
- `out_ready` outside DONE is ignored.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from the inputs.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` = 1 (the cycle after `rst` is sampled high, and while held).
  - `out_valid` = 0, `dec` = 12'h000, `mag` = 0, `cnt` = 0, `s_q` = 0.
- `rst` overrides everything.
  - Asserting it mid-SHIFT, SIGN or DONE aborts the conversion.
  - No `out_valid` pulse is produced for the aborted code.
- Latency: the accept edge is edge 0.
  - Edges 1..E do the shifts.
  - Edge E+1 enters SIGN.
  - Edge E+2 enters DONE, so `out_valid` rises after edge E+2.
  - This is 2 cycles for E=0 and 9 cycles for E=7.
- Minimum initiation interval is E+4 cycles: accept, E+1 SHIFT, SIGN, DONE with immediate `out_ready`, then back to IDLE.
- A new accept is possible on the first edge after returning to IDLE.
- Backpressure: DONE holds indefinitely; `in_ready` stays 0 throughout.

## Test plan
- S=0, E=3'b011, M=4'b1100, `out_ready`=1:
  - `dec` = 12'h060 (96).
  - `out_valid` rises after edge 5; IDLE after edge 6.
- S=1, E=7, M=15:
  - `dec` = 12'h880 (−1920).
  - Latency 9 edges.
- S=1, E=0, M=0:
  - `dec` = 12'h000.
  - Latency 2 edges.
- Zero with nonzero exponent: S=0, E=5, M=0:
  - `dec` = 12'h000 after 7 edges.
- Backpressure: S=0, E=1, M=9, with `out_ready` low for 5 cycles after `out_valid`:
  - `dec` holds 12'h012 and `out_valid` holds 1.
  - `in_ready` stays 0; a second `in_valid` pulse is ignored.
  - Result is consumed on the first edge with `out_ready` high.
- Reset and round-trip:
  - Reset mid-SHIFT (E=6, `rst` at edge 3): `in_ready` = 1, `out_valid` = 0 and `dec` = 12'h000 the next cycle, with no output pulse.
  - Sweep all 256 codes: each `dec` must equal the signed value of M<<E.
  - For normalized codes (M[3]=1 or E=0), feeding `dec` to `FPCVT` must return the identical S/E/M.
